// File: rtl/mips_mem_bridge_pkg.sv
// Shared types for the MIPS core <-> ideal memory bridge: channel FSM states,
// request record, wait-counter width and the byte-strobe merge helper.
package mips_mem_bridge_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } chan_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } chan_req_t;

    // Byte i of the result comes from new_word when strb[i] is set, else from old_word.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        m = old_word;
        for (int i = 0; i < 4; i++)
            if (strb[i]) m[8*i +: 8] = new_word[8*i +: 8];
        return m;
    endfunction

endpackage

// File: rtl/mips_mem_chan.sv
// One bridge channel: IDLE -> WAIT (LAT cycles) -> ACCESS (1 cycle) -> RESP.
// MIPS_MEM_BRIDGE_ALIGN_CHECK_EN additionally flags misaligned addresses as errors.
module mips_mem_chan
    import mips_mem_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LAT        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  chan_req_t             req,
    output logic [ADDR_WIDTH-1:0] word_idx,
    output logic                  rd_en,
    output logic                  wr_en,
    output logic [3:0]            acc_wstrb,
    output logic [31:0]           acc_wdata,
    input  logic [31:0]           rd_data,
    output logic                  resp_valid,
    output logic [31:0]           rdata,
    output logic                  err
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);

    chan_state_t      state;
    logic [CNT_W-1:0] cnt;
    chan_req_t        held;
    logic             bad;

`ifdef MIPS_MEM_BRIDGE_ALIGN_CHECK_EN
    assign bad = (|held.addr[31:ADDR_WIDTH]) || (|held.addr[1:0]);
`else
    // Byte offset is ignored: the access goes to the containing word.
    logic unused_lsb;
    assign unused_lsb = ^held.addr[1:0];
    assign bad = |held.addr[31:ADDR_WIDTH];
`endif

    assign req_ready = (state == ST_IDLE) && !rst;
    assign rd_en     = (state == ST_ACCESS) && !bad;
    // Reset in the access cycle must not let a half-finished store reach memory.
    assign wr_en     = rd_en && held.we && (|held.wstrb) && !rst;
    assign word_idx  = {2'b00, held.addr[ADDR_WIDTH-1:2]};
    assign acc_wstrb = held.wstrb;
    assign acc_wdata = held.wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            held       <= '0;
            resp_valid <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        held  <= req;
                        cnt   <= LAT_CNT;
                        state <= (LAT == 0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 1) state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    rdata      <= bad ? '0 : rd_data;
                    err        <= bad;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mips_mem_bridge.sv
// Bridge between the multi-cycle MIPS core and the ideal memory: IF channel on read
// port 1, DM channel on read port 2 + write port. Option: MIPS_MEM_BRIDGE_ALIGN_CHECK_EN.
module mips_mem_bridge
    import mips_mem_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LAT        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [31:0]           if_addr,
    output logic                  if_resp_valid,
    output logic [31:0]           if_rdata,
    output logic                  if_err,
    input  logic                  dm_req_valid,
    output logic                  dm_req_ready,
    input  logic [31:0]           dm_addr,
    input  logic                  dm_we,
    input  logic [3:0]            dm_wstrb,
    input  logic [31:0]           dm_wdata,
    output logic                  dm_resp_valid,
    output logic [31:0]           dm_rdata,
    output logic                  dm_err,
    output logic [ADDR_WIDTH-1:0] mem_Raddr1,
    output logic [ADDR_WIDTH-1:0] mem_Raddr2,
    output logic [ADDR_WIDTH-1:0] mem_Waddr,
    output logic                  mem_Rden1,
    output logic                  mem_Rden2,
    output logic                  mem_Wren,
    output logic [31:0]           mem_Wdata,
    input  logic [31:0]           mem_Rdata1,
    input  logic [31:0]           mem_Rdata2
);

    chan_req_t             if_req, dm_req;
    logic [ADDR_WIDTH-1:0] dm_idx;
    logic [3:0]            dm_acc_wstrb;
    logic [31:0]           dm_acc_wdata;
    logic                  if_wr_en_unused;
    logic [3:0]            if_wstrb_unused;
    logic [31:0]           if_wdata_unused;

    assign if_req = '{addr: if_addr, we: 1'b0, wstrb: 4'h0, wdata: 32'h0};
    assign dm_req = '{addr: dm_addr, we: dm_we, wstrb: dm_wstrb, wdata: dm_wdata};

    mips_mem_chan #(.ADDR_WIDTH(ADDR_WIDTH), .LAT(LAT)) u_if (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (if_req_valid),
        .req_ready  (if_req_ready),
        .req        (if_req),
        .word_idx   (mem_Raddr1),
        .rd_en      (mem_Rden1),
        .wr_en      (if_wr_en_unused),
        .acc_wstrb  (if_wstrb_unused),
        .acc_wdata  (if_wdata_unused),
        .rd_data    (mem_Rdata1),
        .resp_valid (if_resp_valid),
        .rdata      (if_rdata),
        .err        (if_err)
    );

    mips_mem_chan #(.ADDR_WIDTH(ADDR_WIDTH), .LAT(LAT)) u_dm (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (dm_req_valid),
        .req_ready  (dm_req_ready),
        .req        (dm_req),
        .word_idx   (dm_idx),
        .rd_en      (mem_Rden2),
        .wr_en      (mem_Wren),
        .acc_wstrb  (dm_acc_wstrb),
        .acc_wdata  (dm_acc_wdata),
        .rd_data    (mem_Rdata2),
        .resp_valid (dm_resp_valid),
        .rdata      (dm_rdata),
        .err        (dm_err)
    );

    // Store word = new bytes merged over the old word read asynchronously on port 2.
    assign mem_Raddr2 = dm_idx;
    assign mem_Waddr  = dm_idx;
    assign mem_Wdata  = strb_merge(mem_Rdata2, dm_acc_wdata, dm_acc_wstrb);

endmodule
